// File: rtl/char_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : char_pixel_writer
// Purpose  : Expands one 8x8 text character into 64 pixel writes. Each of the
//            eight glyph rows is fetched from an external glyph ROM (one-cycle
//            read latency) and is then streamed out left to right under a
//            valid/ready handshake.
// Ports    : clk, rst_n              - clock, asynchronous active-low reset
//            req_valid/req_ready     - character draw request handshake
//            char_x/char_y/char_code - character cell and glyph index
//            rom_addr/rom_data       - glyph ROM read port
//            px_valid/px_ready       - pixel write handshake
//            px_x/px_y/px_on         - pixel coordinate and glyph bit
//            done                    - one-cycle pulse after the last pixel
//            err                     - one-cycle pulse on a rejected request
// Config   : CHAR_BOUNDS_CHECK_EN - when defined, requests outside the
//            COLS x ROWS grid are rejected with an err pulse.
// Revision : 1.0 - initial release
// ============================================================================
module char_pixel_writer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  char_x,
  input  logic [6:0]  char_y,
  input  logic [7:0]  char_code,
  output logic [10:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_on,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_EMIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [8:0] COLS_LIM = 9'(COLS);
  localparam logic [7:0] ROWS_LIM = 8'(ROWS);

  state_t      state_q, state_d;
  // Only seven bits of the column are kept: in-range columns fit, and
  // char_x*8 must fit the 10-bit pixel coordinate anyway.
  logic [6:0]  cx_q, cx_d;
  logic [6:0]  cy_q, cy_d;
  logic [7:0]  code_q, code_d;
  logic [2:0]  row_q, row_d;
  logic [2:0]  col_q, col_d;
  // Glyph row shift register: bit 7 is always the pixel currently on offer.
  logic [7:0]  bits_q, bits_d;
  logic        err_q, err_d;

  logic        oob;
  logic        reject;

  assign oob = ({1'b0, char_x} >= COLS_LIM) || ({1'b0, char_y} >= ROWS_LIM);

`ifdef CHAR_BOUNDS_CHECK_EN
  assign reject = oob;
  assign err    = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{oob, err_q};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      code_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      bits_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      code_q  <= code_d;
      row_q   <= row_d;
      col_q   <= col_d;
      bits_q  <= bits_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    code_d    = code_q;
    row_d     = row_q;
    col_d     = col_q;
    bits_d    = bits_q;
    err_d     = 1'b0;
    req_ready = 1'b0;
    rom_addr  = '0;
    px_valid  = 1'b0;
    px_x      = '0;
    px_y      = '0;
    px_on     = 1'b0;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            cx_d    = char_x[6:0];
            cy_d    = char_y;
            code_d  = char_code;
            row_d   = '0;
            col_d   = '0;
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        rom_addr = {code_q, row_q};
        state_d  = S_WAIT;
      end

      // ROM answers one cycle after the address was presented.
      S_WAIT: begin
        bits_d  = rom_data;
        state_d = S_EMIT;
      end

      S_EMIT: begin
        px_valid = 1'b1;
        // Multiplying by 8 is a concatenation because col/row are 3 bits.
        px_x     = {cx_q, col_q};
        px_y     = {cy_q, row_q};
        px_on    = bits_q[7];
        if (px_ready) begin
          bits_d = {bits_q[6:0], 1'b0};
          col_d  = col_q + 3'd1;
          if (col_q == 3'd7) begin
            if (row_q == 3'd7) begin
              state_d = S_DONE;
            end else begin
              row_d   = row_q + 3'd1;
              state_d = S_FETCH;
            end
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_char_pixel_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_char_pixel_writer
// Purpose  : Directed self-checking bench for char_pixel_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_char_pixel_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  char_x;
  logic [6:0]  char_y;
  logic [7:0]  char_code;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        px_valid;
  logic        px_ready;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic        px_on;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  // results of the most recent draw
  int          n_pix, n_bad, n_unstable, done_cyc, first_valid_cyc;
  logic [9:0]  first_x, first_y, last_x, last_y;
  logic        on_seq [0:63];
  logic [10:0] addrs [$];

  char_pixel_writer #(.COLS(80), .ROWS(60)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .char_x    (char_x),
    .char_y    (char_y),
    .char_code (char_code),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .px_valid  (px_valid),
    .px_ready  (px_ready),
    .px_x      (px_x),
    .px_y      (px_y),
    .px_on     (px_on),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Glyph ROM model: glyph 0xEE is 0x81 on every row, others a fixed pattern.
  function automatic logic [7:0] glyph(input logic [10:0] a);
    if (a[10:3] == 8'hEE) return 8'h81;
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(posedge clk) rom_data <= glyph(rom_addr);

  // Drives one request and records what the DUT produced until done.
  task automatic draw_char(input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] code, input bit stall, input bit hold);
    logic [20:0] held;
    bit          have_held;
    logic [7:0]  g;
    int          r, c, ex, ey;
    n_pix = 0; n_bad = 0; n_unstable = 0; done_cyc = 0; first_valid_cyc = 0;
    first_x = '0; first_y = '0; last_x = '0; last_y = '0;
    addrs.delete();
    have_held = 0;
    held = '0;
    @(negedge clk);
    req_valid = 1'b1; char_x = x; char_y = y; char_code = code; px_ready = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(posedge clk); #1;
      if (!hold) begin
        req_valid = 1'b0;
        char_x = 8'($urandom); char_y = 7'($urandom); char_code = 8'($urandom);
      end
      if (rom_addr != 11'd0) addrs.push_back(rom_addr);
      if (px_valid && first_valid_cyc == 0) first_valid_cyc = cyc;
      if (have_held && px_valid && ({px_x, px_y, px_on} !== held)) n_unstable++;
      have_held = 0;
      px_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (px_valid) begin
        if (px_ready) begin
          r  = n_pix / 8;
          c  = n_pix % 8;
          ex = int'(x) * 8 + c;
          ey = int'(y) * 8 + r;
          g  = glyph({code, 3'(r)});
          if (px_x !== 10'(ex) || px_y !== 10'(ey) || px_on !== g[7-c]) n_bad++;
          if (n_pix == 0) begin first_x = px_x; first_y = px_y; end
          if (n_pix < 64) on_seq[n_pix] = px_on;
          last_x = px_x; last_y = px_y;
          n_pix++;
        end else begin
          have_held = 1;
          held = {px_x, px_y, px_on};
        end
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; px_ready = 1'b0;
    char_x = '0; char_y = '0; char_code = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL reset_px_valid got %b want 0", px_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    checks++; if (px_x !== 10'd0 || px_y !== 10'd0) begin errors++; $display("FAIL reset_px_xy got %0d,%0d want 0,0", px_x, px_y); end
    checks++; if (px_on !== 1'b0) begin errors++; $display("FAIL reset_px_on got %b want 0", px_on); end
    checks++; if (rom_addr !== 11'd0) begin errors++; $display("FAIL reset_rom_addr got %h want 0", rom_addr); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic_char();
    draw_char(8'd3, 7'd2, 8'h41, 1'b0, 1'b0);
    checks++; if (done_cyc !== 81) begin errors++; $display("FAIL basic_done_cycle got %0d want 81", done_cyc); end
    checks++; if (first_valid_cyc !== 3) begin errors++; $display("FAIL basic_first_px_latency got %0d want 3", first_valid_cyc); end
    checks++; if (n_pix !== 64) begin errors++; $display("FAIL basic_pixel_count got %0d want 64", n_pix); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL basic_pixel_values got %0d bad want 0", n_bad); end
    checks++; if (first_x !== 10'd24 || first_y !== 10'd16) begin errors++; $display("FAIL basic_first_px got %0d,%0d want 24,16", first_x, first_y); end
    checks++; if (last_x !== 10'd31 || last_y !== 10'd23) begin errors++; $display("FAIL basic_last_px got %0d,%0d want 31,23", last_x, last_y); end
    checks++; if (addrs.size() !== 8) begin errors++; $display("FAIL basic_rom_addr_count got %0d want 8", addrs.size()); end
    for (int i = 0; i < addrs.size() && i < 8; i++) begin
      checks++;
      if (addrs[i] !== 11'(11'h208 + i)) begin errors++; $display("FAIL basic_rom_addr[%0d] got %h want %h", i, addrs[i], 11'h208 + i); end
    end
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL basic_idle_after_done got ready=%b done=%b want 1,0", req_ready, done); end
  endtask

  task automatic test_glyph_bits();
    logic [7:0] row0;
    draw_char(8'd0, 7'd0, 8'hEE, 1'b0, 1'b0);
    row0 = '0;
    for (int i = 0; i < 8; i++) row0[7-i] = on_seq[i];
    checks++; if (row0 !== 8'h81) begin errors++; $display("FAIL glyph_81_row got %h want 81", row0); end
    checks++; if (n_bad !== 0 || n_pix !== 64) begin errors++; $display("FAIL glyph_81_pixels got %0d bad of %0d want 0 of 64", n_bad, n_pix); end
    @(posedge clk);
  endtask

  task automatic test_stalls();
    draw_char(8'd3, 7'd2, 8'h41, 1'b1, 1'b0);
    checks++; if (done_cyc == 0) begin errors++; $display("FAIL stall_done got timeout want done pulse"); end
    checks++; if (n_pix !== 64) begin errors++; $display("FAIL stall_pixel_count got %0d want 64", n_pix); end
    checks++; if (n_bad !== 0) begin errors++; $display("FAIL stall_pixel_values got %0d bad want 0", n_bad); end
    checks++; if (n_unstable !== 0) begin errors++; $display("FAIL stall_stability got %0d changes want 0", n_unstable); end
    checks++; if (last_x !== 10'd31 || last_y !== 10'd23) begin errors++; $display("FAIL stall_last_px got %0d,%0d want 31,23", last_x, last_y); end
    @(posedge clk);
    px_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    int npx, late_px, late_done;
    bit hit;
    npx = 0; hit = 0; late_px = 0; late_done = 0;
    @(negedge clk);
    req_valid = 1'b1; char_x = 8'd5; char_y = 7'd5; char_code = 8'h41; px_ready = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (px_valid) npx++;
      if (npx == 20) begin
        hit = 1;
        rst_n = 1'b0;
        #1;
        checks++; if (px_valid !== 1'b0) begin errors++; $display("FAIL midreset_px_valid got %b want 0", px_valid); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midreset_req_ready got %b want 1", req_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", done); end
        break;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL midreset_reach_px20 got %0d pixels want 20", npx); end
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(posedge clk); #1;
      if (px_valid) late_px++;
      if (done) late_done++;
    end
    checks++; if (late_px !== 0 || late_done !== 0) begin errors++; $display("FAIL midreset_after_release got px=%0d done=%0d want 0,0", late_px, late_done); end
  endtask

  task automatic test_max_coord();
    draw_char(8'd79, 7'd59, 8'h10, 1'b0, 1'b0);
    checks++; if (n_pix !== 64 || n_bad !== 0) begin errors++; $display("FAIL maxcoord_pixels got %0d bad of %0d want 0 of 64", n_bad, n_pix); end
    checks++; if (last_x !== 10'd639 || last_y !== 10'd479) begin errors++; $display("FAIL maxcoord_last_px got %0d,%0d want 639,479", last_x, last_y); end
    @(posedge clk);
  endtask

  task automatic test_back_to_back();
    draw_char(8'd1, 7'd1, 8'h41, 1'b0, 1'b1);
    checks++; if (n_pix !== 64 || n_bad !== 0 || done_cyc !== 81) begin errors++; $display("FAIL b2b_first got %0d px %0d bad done@%0d want 64,0,81", n_pix, n_bad, done_cyc); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_accept_in_done got ready=%b want 0", req_ready); end
    char_x = 8'd2; char_y = 7'd1; char_code = 8'h42;
    @(posedge clk); #1;
    checks++; if (req_ready !== 1'b1 || px_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap got ready=%b px_valid=%b want 1,0", req_ready, px_valid); end
    draw_char(8'd2, 7'd1, 8'h42, 1'b0, 1'b0);
    checks++; if (n_pix !== 64 || n_bad !== 0 || done_cyc !== 81) begin errors++; $display("FAIL b2b_second got %0d px %0d bad done@%0d want 64,0,81", n_pix, n_bad, done_cyc); end
    checks++; if (first_x !== 10'd16 || first_y !== 10'd8) begin errors++; $display("FAIL b2b_second_first_px got %0d,%0d want 16,8", first_x, first_y); end
    @(posedge clk);
  endtask

`ifdef CHAR_BOUNDS_CHECK_EN
  task automatic test_bounds_err();
    int n_px, n_err;
    n_px = 0; n_err = 0;
    @(negedge clk);
    req_valid = 1'b1; char_x = 8'd80; char_y = 7'd0; char_code = 8'h41;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bounds_err_pulse got %b want 1", err); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bounds_ready_next got %b want 1", req_ready); end
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (px_valid) n_px++;
      if (err) n_err++;
    end
    checks++; if (n_px !== 0 || n_err !== 0) begin errors++; $display("FAIL bounds_quiet got px=%0d err=%0d want 0,0", n_px, n_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_char();
    test_glyph_bits();
    test_stalls();
    test_reset_mid();
    test_max_coord();
    test_back_to_back();
`ifdef CHAR_BOUNDS_CHECK_EN
    test_bounds_err();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/char_pixel_writer.md
CHAR_PIXEL_WRITER -- requirements
Module: char_pixel_writer

Interface
REQ-001 Parameter COLS, default 80, meaning: number of character columns in the text grid.
REQ-002 Parameter ROWS, default 60, meaning: number of character rows in the text grid.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  character draw request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 char_x  input  8  target character column.
REQ-008 char_y  input  7  target character row.
REQ-009 char_code  input  8  glyph index.
REQ-010 rom_addr  output  11  glyph ROM address, {char_code, row[2:0]}.
REQ-011 rom_data  input  8  glyph row bits, valid one cycle after rom_addr; bit 7 = leftmost pixel.
REQ-012 px_valid  output  1  pixel write present.
REQ-013 px_ready  input  1  framebuffer accepts pixel.
REQ-014 px_x  output  10  pixel column.
REQ-015 px_y  output  10  pixel row.
REQ-016 px_on  output  1  glyph bit for the pixel (1 = foreground).
REQ-017 done  output  1  one-cycle pulse after the last pixel of a character is accepted.
REQ-018 err  output  1  one-cycle pulse on a rejected request (only with CHAR_BOUNDS_CHECK_EN).

Function
REQ-019 The block SHALL implement states IDLE, FETCH, WAIT, EMIT, DONE.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid && req_ready, latching char_x, char_y, char_code, with row := 0, col := 0, and the transition IDLE->FETCH.
REQ-021 In FETCH, rom_addr SHALL equal {latched char_code, row}; FETCH->WAIT unconditionally.
REQ-022 In WAIT, rom_data SHALL be captured into a row shift register; WAIT->EMIT unconditionally.
REQ-023 In EMIT, px_valid SHALL be 1, with px_x = char_x*8 + col, px_y = char_y*8 + row (10-bit results, no truncation for in-range inputs), and px_on = captured bit (7 - col).
REQ-024 px_x, px_y, and px_on SHALL remain stable while px_valid && !px_ready.
REQ-025 On px_ready in EMIT, col SHALL increment; when col == 7, the next state SHALL be FETCH with row+1 if row < 7, otherwise DONE.
REQ-026 DONE SHALL assert done for exactly one cycle, then return to IDLE; a new request SHALL NOT be accepted in the DONE cycle.
REQ-027 The minimum latency from acceptance to the first px_valid SHALL be 2 cycles; a full character with px_ready held high SHALL take 8*(2+8) + 1 = 81 cycles to the done pulse.
REQ-028 px_valid SHALL be 0 in all states except EMIT.
REQ-029 Input changes on char_x, char_y, or char_code during a draw SHALL have no effect.

Reset
REQ-030 While rst_n = 0, the state SHALL be IDLE and req_ready=1, px_valid=0, done=0, err=0, px_x=0, px_y=0, px_on=0, and rom_addr=0.
REQ-031 Reset asserted mid-character SHALL abort the draw immediately, with no done pulse and no further pixels after release.

Configuration
REQ-032 With macro CHAR_BOUNDS_CHECK_EN defined, an accepted request with char_x >= COLS or char_y >= ROWS SHALL emit no pixels, pulse err for one cycle, and remain in IDLE.
REQ-033 Without CHAR_BOUNDS_CHECK_EN, err SHALL be tied to 0 and every request SHALL be drawn, with px_x and px_y computed per REQ-023.

Verification
REQ-034 Request (3,2,0x41) with px_ready=1 and a ROM model -> 64 pixels, the first at (24,16) and the last at (31,23), rom_addr sequence 0x208..0x20F, and done at cycle 81.
REQ-035 Random px_ready stalls -> no pixel dropped or duplicated, with outputs stable during stalls and an identical pixel set to REQ-034.
REQ-036 Glyph row 0x81 -> px_on = 1,0,0,0,0,0,0,1 across col 0..7.
REQ-037 rst_n pulsed low at pixel 20 -> px_valid=0 and req_ready=1 immediately, with no done pulse.
REQ-038 Request (79,59) -> last pixel (639,479); with CHAR_BOUNDS_CHECK_EN, request (80,0) -> err pulse, zero pixels, and req_ready=1 on the next cycle.
REQ-039 Back-to-back requests with req_valid held high -> the second is accepted the cycle after done, with no overlap of pixels.
